// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider (div_seq_unit) and its
// combinational iteration step (div_step).
//   DIV_W       : default operand/result width
//   CNT_W       : iteration counter width for the default operand width
//   div_state_e : controller states IDLE/SETUP/ITER/FIX/DONE
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_seq_unit_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring radix-2 iteration on unsigned magnitudes. Kept as its own block
// so two copies can later be chained for a radix-4 iteration.
// Ports:
//   rem      in  WIDTH  partial remainder (always < div)
//   q        in  WIDTH  dividend bits still to shift in / quotient bits so far
//   div      in  WIDTH  divisor magnitude
//   rem_nxt  out WIDTH  partial remainder after this step
//   q_nxt    out WIDTH  quotient register after this step
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < div <= 2^(WIDTH-1) keeps the shifted remainder inside WIDTH+1 bits;
  // the top bit of the difference is the borrow (trial < 0).
  assign shifted = {rem, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, div};

  always_comb begin
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_unit.sv
// -----------------------------------------------------------------------------
// div_seq_unit
// Multicycle signed divider for the multicycle MIPS core (DIV semantics):
// quotient truncated toward zero on lo_out, remainder with the dividend's sign
// on hi_out. A divide by zero leaves hi_out/lo_out untouched and raises
// div_zero together with div_stop; the control unit takes the exception.
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high; clears all state
//   start     in   1      begin a division (only honoured in IDLE)
//   dividend  in   WIDTH  signed dividend (A register)
//   divisor   in   WIDTH  signed divisor (B register)
//   hi_out    out  WIDTH  remainder
//   lo_out    out  WIDTH  quotient
//   div_stop  out  1      one-cycle completion pulse
//   div_zero  out  1      one-cycle divide-by-zero pulse, coincident with div_stop
// Configuration macro:
//   DIV_EARLY_OUT_EN  when defined, |dividend| < |divisor| skips the iteration
//                     phase (result q=0, rem=|dividend|), completing 3 edges
//                     after start instead of WIDTH+3.
// -----------------------------------------------------------------------------
module div_seq_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_stop,
  output logic             div_zero
);

  // The package constant already covers the default width.
  localparam int CW = (WIDTH == DIV_W) ? CNT_W : $clog2(WIDTH);

  div_state_e       state, state_nxt;
  logic             sa, sb;
  logic             zero_flag;
  logic [WIDTH-1:0] a_lat, b_lat;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem, q, dv;
  logic [WIDTH-1:0] rem_step, q_step;
  logic [CW-1:0]    cnt;
  logic             last_iter;
  logic             early;

  // Unsigned magnitudes: the most negative value maps onto itself, which is
  // exactly its magnitude when read as unsigned.
  assign abs_a     = sa ? -a_lat : a_lat;
  assign abs_b     = sb ? -b_lat : b_lat;
  assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .q       (q),
    .div     (dv),
    .rem_nxt (rem_step),
    .q_nxt   (q_step)
  );

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default is assigned before the case so every path drives
  // state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP: begin
        if (b_lat == '0) state_nxt = DONE;
        else if (early)  state_nxt = FIX;
        else             state_nxt = ITER;
      end
      ITER:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_lat     <= '0;
      b_lat     <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      zero_flag <= 1'b0;
      rem       <= '0;
      q         <= '0;
      dv        <= '0;
      cnt       <= '0;
      hi_out    <= '0;
      lo_out    <= '0;
      div_stop  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Operands are captured once; later changes on the A/B registers
          // cannot disturb a running division.
          if (start) begin
            a_lat     <= dividend;
            b_lat     <= divisor;
            sa        <= dividend[WIDTH-1];
            sb        <= divisor[WIDTH-1];
            zero_flag <= 1'b0;
          end
        end
        SETUP: begin
          if (b_lat == '0) begin
            zero_flag <= 1'b1;
          end else if (early) begin
            q   <= '0;
            rem <= abs_a;
            dv  <= abs_b;
            cnt <= '0;
          end else begin
            q   <= abs_a;
            rem <= '0;
            dv  <= abs_b;
            cnt <= '0;
          end
        end
        ITER: begin
          rem <= rem_step;
          q   <= q_step;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          lo_out <= (sa ^ sb) ? -q : q;
          hi_out <= sa ? -rem : rem;
        end
        default: ;
      endcase

      // Pulses are registered out of DONE so they are glitch-free and land
      // one edge after the controller reaches DONE.
      div_stop <= (state == DONE);
      div_zero <= (state == DONE) && zero_flag;
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
module tb_div_seq_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  dividend, divisor;
  logic [W-1:0]  hi_out, lo_out;
  logic          div_stop, div_zero;

  always #5 clk = ~clk;

  div_seq_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .div_stop (div_stop),
    .div_zero (div_zero)
  );

  typedef struct {
    string        name;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         zero;
    int           stop_edge;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   errors    = 0;
  int   edge_cnt  = 0;
  int   stop_seen = 0;
  int   exp_stops = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every completion pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && div_zero) check("zero_needs_stop", {31'b0, div_stop}, 32'd1);
    if (!reset && div_stop) begin
      stop_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stop: got div_stop=1 at edge %0d, expected no completion", edge_cnt);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_lo"},   lo_out, mon_e.lo);
        check({mon_e.name, "_hi"},   hi_out, mon_e.hi);
        check({mon_e.name, "_zero"}, {31'b0, div_zero}, {31'b0, mon_e.zero});
        check({mon_e.name, "_edge"}, W'(edge_cnt), W'(mon_e.stop_edge));
      end
    end
  end

  function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ua, ub;
    ua = a[W-1] ? -a : a;
    ub = b[W-1] ? -b : b;
    if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ua < ub) return 3;
`endif
    return W + 3;
  endfunction

  // Reference division using the simulator's signed integer arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi);
    int ai, bi;
    ai = a;
    bi = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = a;
      hi = '0;
    end else begin
      lo = ai / bi;
      hi = ai % bi;
    end
  endfunction

  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lo, input logic [W-1:0] hi, input logic zero);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.name      = name;
    e.lo        = lo;
    e.hi        = hi;
    e.zero      = zero;
    e.stop_edge = edge_cnt + 1 + latency(a, b);
    sb_q.push_back(e);
    exp_stops++;
    @(negedge clk);
    start    = 1'b0;
    // Scramble the operand registers while the division runs.
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_stop(input string name);
    for (int i = 0; i < 100 && stop_seen < exp_stops; i++) @(negedge clk);
    @(negedge clk);
    if (stop_seen < exp_stops) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d completions, expected %0d", name, stop_seen, exp_stops);
      sb_q.delete();
      exp_stops = stop_seen;
    end
  endtask

  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] lo, input logic [W-1:0] hi, input logic zero);
    issue(name, a, b, lo, hi, zero);
    wait_stop(name);
  endtask

  initial begin
    int n;
    logic [W-1:0] a, b, lo, hi;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_hi",   hi_out, '0);
    check("rst_lo",   lo_out, '0);
    check("rst_stop", {31'b0, div_stop}, 32'd0);
    check("rst_zero", {31'b0, div_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    run("p100_p7",   32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
    run("m100_p7",   -32'd100,      32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run("p100_m7",   32'd100,       -32'd7,        32'hFFFF_FFF2, 32'd2,         1'b0);
    run("m7_m2",     -32'd7,        -32'd2,        32'd3,         32'hFFFF_FFFF, 1'b0);
    run("intmin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    run("intmin_p2", 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0);
    run("intmax_p1", 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'd0,         1'b0);
    run("m1_intmin", 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1'b0);
    run("p3_p9",     32'd3,         32'd9,         32'd0,         32'd3,         1'b0);
    // Divide by zero keeps the previous (3 / 9) results.
    run("p5_zero",   32'd5,         32'd0,         32'd0,         32'd3,         1'b1);

    // Restart attempt during ITER must be ignored.
    issue("restart", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (8) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_stop("restart");
    repeat (40) @(negedge clk);

    // Reset in the middle of a division: outputs clear, no completion.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    n        = edge_cnt + 1;
    @(negedge clk);
    start    = 1'b0;
    while (edge_cnt < n + 9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_hi",   hi_out, '0);
    check("midrst_lo",   lo_out, '0);
    check("midrst_stop", {31'b0, div_stop}, 32'd0);
    repeat (50) @(negedge clk);

    run("post_rst", 32'd45, -32'd6, 32'hFFFF_FFF9, 32'd3, 1'b0);

    // Random signed pairs against the reference model.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(1, 20));
        1:       b = -W'($urandom_range(1, 1000));
        2:       b = $urandom;
        default: begin
          a = W'($urandom_range(0, 60)) - 32'd30;
          b = $urandom;
        end
      endcase
      if (b == '0) b = 32'd1;
      ref_div(a, b, lo, hi);
      run("rand", a, b, lo, hi, 1'b0);
    end

    check("sb_empty", W'(sb_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
